mem_port_arbiter: RTL

- Shares one single-port unified instruction/data memory between instruction fetch (IF) and load/store (LS).
- Carries one outstanding transaction at a time.
- Builds byte enables and lane-replicated write data from funct3 and the address.
- Sign/zero-extends load data, flags misaligned or illegal accesses, and drives the pipeline stall.

---
 rtl/mem_port_arbiter.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store,
// one transaction in flight, with lane steering and load extension.
module mem_port_arbiter #(
   parameter int AW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_gnt_o,
   output logic          if_rvalid_o,
   output logic [31:0]   if_rdata_o,
   output logic          if_err_o,
   input  logic          ls_req_i,
   input  logic          ls_we_i,
   input  logic [2:0]    ls_funct3_i,
   input  logic [AW-1:0] ls_addr_i,
   input  logic [31:0]   ls_wdata_i,
   output logic          ls_gnt_o,
   output logic          ls_rvalid_o,
   output logic [31:0]   ls_rdata_o,
   output logic          ls_err_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [3:0]    mem_be_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i,
   input  logic          mem_rvalid_i,
   output logic          stall_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR
   } state_t;

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   state_t      state;
   logic        owner_ls;
   logic        cap_we;
   logic [1:0]  cap_off;
   logic [2:0]  cap_f3;
   logic [3:0]  starve_cnt;
   logic        idle;
   logic        if_win;
   logic        ls_win;
   logic        if_legal;
   logic        ls_legal;
   logic [3:0]  ls_be;
   logic [31:0] ls_wd;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;
   logic [31:0] ld_ext;

   assign idle     = (state == S_IDLE);
   assign if_win   = if_req_i & (~ls_req_i | (starve_cnt == SMAX));
   assign ls_win   = ls_req_i & ~if_win;
   assign if_gnt_o = rst_ni & idle & if_win;
   assign ls_gnt_o = rst_ni & idle & ls_win;
   assign stall_o  = rst_ni & (~idle
                   | ((if_req_i | ls_req_i) & ~(if_gnt_o | ls_gnt_o))
                   | (idle & if_req_i & ls_req_i));
   assign if_legal = (if_addr_i[1:0] == 2'b00);

   // Alignment and funct3 legality of the pending load/store
   always_comb begin
      ls_legal = 1'b0;
      case (ls_funct3_i)
         3'd0, 3'd4: ls_legal = 1'b1;
         3'd1, 3'd5: ls_legal = ~ls_addr_i[0];
         3'd2:       ls_legal = (ls_addr_i[1:0] == 2'b00);
         default:    ls_legal = 1'b0;
      endcase
      if (ls_we_i && ls_funct3_i[2]) ls_legal = 1'b0;
   end

   // Byte enables and lane-replicated store data
   always_comb begin
      ls_be = 4'b1111;
      ls_wd = ls_wdata_i;
      if (ls_we_i) begin
         case (ls_funct3_i[1:0])
            2'd0: begin
               ls_be = 4'b0001 << ls_addr_i[1:0];
               ls_wd = {4{ls_wdata_i[7:0]}};
            end
            2'd1: begin
               ls_be = ls_addr_i[1] ? 4'b1100 : 4'b0011;
               ls_wd = {2{ls_wdata_i[15:0]}};
            end
            default: ;
         endcase
      end
   end

   assign lane_b = 8'(mem_rdata_i >> {cap_off, 3'b000});
   assign lane_h = 16'(mem_rdata_i >> {cap_off[1], 4'b0000});

   // Sign/zero extension of the returned word for the captured load
   always_comb begin
      case (cap_f3)
         3'd0:    ld_ext = {{24{lane_b[7]}}, lane_b};
         3'd4:    ld_ext = {24'h0, lane_b};
         3'd1:    ld_ext = {{16{lane_h[15]}}, lane_h};
         3'd5:    ld_ext = {16'h0, lane_h};
         default: ld_ext = mem_rdata_i;
      endcase
   end

   // Transaction FSM with registered memory and response outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= S_IDLE;
         owner_ls    <= 1'b0;
         cap_we      <= 1'b0;
         cap_off     <= 2'b00;
         cap_f3      <= 3'd0;
         starve_cnt  <= 4'd0;
         if_rvalid_o <= 1'b0;
         if_rdata_o  <= 32'h0;
         if_err_o    <= 1'b0;
         ls_rvalid_o <= 1'b0;
         ls_rdata_o  <= 32'h0;
         ls_err_o    <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= 4'h0;
         mem_addr_o  <= '0;
         mem_wdata_o <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               unique case (1'b1)
                  ls_win: begin
                     owner_ls <= 1'b1;
                     cap_we   <= ls_we_i;
                     cap_off  <= ls_addr_i[1:0];
                     cap_f3   <= ls_funct3_i;
                     if (if_req_i && starve_cnt != SMAX)
                        starve_cnt <= starve_cnt + 4'd1;
                     if (ls_legal) begin
                        state       <= S_ISSUE;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= ls_we_i;
                        mem_be_o    <= ls_be;
                        mem_addr_o  <= {ls_addr_i[AW-1:2], 2'b00};
                        mem_wdata_o <= ls_wd;
                     end else begin
                        state       <= S_ERR;
                        ls_rvalid_o <= 1'b1;
                        ls_err_o    <= 1'b1;
                        ls_rdata_o  <= 32'h0;
                     end
                  end
                  if_win: begin
                     owner_ls   <= 1'b0;
                     cap_we     <= 1'b0;
                     cap_off    <= if_addr_i[1:0];
                     cap_f3     <= 3'd2;
                     starve_cnt <= 4'd0;
                     if (if_legal) begin
                        state       <= S_ISSUE;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_be_o    <= 4'b1111;
                        mem_addr_o  <= {if_addr_i[AW-1:2], 2'b00};
                        mem_wdata_o <= 32'h0;
                     end else begin
                        state       <= S_ERR;
                        if_rvalid_o <= 1'b1;
                        if_err_o    <= 1'b1;
                        if_rdata_o  <= 32'h0;
                     end
                  end
                  default: ;
               endcase
            end
            S_ISSUE: begin
               mem_req_o <= 1'b0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (mem_rvalid_i) begin
                  state <= S_RESP;
                  if (owner_ls) begin
                     ls_rvalid_o <= 1'b1;
                     ls_err_o    <= 1'b0;
                     ls_rdata_o  <= cap_we ? 32'h0 : ld_ext;
                  end else begin
                     if_rvalid_o <= 1'b1;
                     if_err_o    <= 1'b0;
                     if_rdata_o  <= mem_rdata_i;
                  end
               end
            end
            S_RESP, S_ERR: begin
               state       <= S_IDLE;
               if_rvalid_o <= 1'b0;
               if_rdata_o  <= 32'h0;
               if_err_o    <= 1'b0;
               ls_rvalid_o <= 1'b0;
               ls_rdata_o  <= 32'h0;
               ls_err_o    <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
